// File: rtl/m68kwb_pkg.sv
// rtl/m68kwb_pkg.sv - shared encodings and constants for the 68000 bus-side helpers
package m68kwb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK  = 3'd1,
        ST_HOLD = 3'd2,
        ST_SPUR = 3'd3,
        ST_TMO  = 3'd4,
        ST_REL  = 3'd5
    } iack_state_e;

    localparam logic [7:0] SPURIOUS_VEC_DEF = 8'd24;
    localparam logic [7:0] AUTOVEC_BASE     = 8'd24;

endpackage

// File: rtl/iack_timer.sv
// rtl/iack_timer.sv - 8-bit loadable down-counter that stops at zero
module iack_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/iack_sequencer.sv
// rtl/iack_sequencer.sv - 68000 interrupt-acknowledge sequencer; IACK_AUTOVEC_EN turns timeouts into autovector requests
module iack_sequencer
    import m68kwb_pkg::*;
#(
    parameter int         TIMEOUT      = 16,
    parameter logic [7:0] SPURIOUS_VEC = SPURIOUS_VEC_DEF
) (
    input  logic       wb_clk_i,
    input  logic       wb_reset_n_i,
    input  logic       cpu_iack_i,
    input  logic [2:0] cpu_lvl_i,
    output logic [7:0] cpu_vec_o,
    output logic       cpu_dtack_o,
    output logic       cpu_avec_o,
    input  logic [2:0] ic_ipl_i,
    output logic       ic_int_ack_o,
    input  logic [7:0] ic_dat_i,
    input  logic       ic_ack_ni,
    output logic [7:0] spur_cnt_o
);

`ifdef IACK_AUTOVEC_EN
    localparam bit AUTOVEC = 1'b1;
`else
    localparam bit AUTOVEC = 1'b0;
`endif

    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

    iack_state_e state_q, state_d;
    logic [7:0]  vec_q, vec_d;
    logic        seen_low_q, seen_low_d;
    logic [7:0]  spur_cnt_q, spur_cnt_d;
    logic [7:0]  cpu_vec_q, cpu_vec_d;
    logic        dtack_q, dtack_d;
    logic        avec_q, avec_d;
    logic        int_ack_q, int_ack_d;
    logic        timer_load;
    logic        timer_expired;

    iack_timer u_timer (
        .clk        (wb_clk_i),
        .rst_n      (wb_reset_n_i),
        .load_i     (timer_load),
        .load_val_i (TIMER_LOAD),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // seen_low blocks re-acceptance of an IACK that was already high across reset
                if (cpu_iack_i && seen_low_q) begin
                    if ((ic_ipl_i == 3'd0) || (ic_ipl_i != cpu_lvl_i)) begin
                        state_d = ST_SPUR;
                    end else begin
                        state_d    = ST_ACK;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (!cpu_iack_i) begin
                    state_d = ST_REL;
                end else if (!ic_ack_ni) begin
                    vec_d   = ic_dat_i;
                    state_d = ST_HOLD;
                end else if (timer_expired) begin
                    state_d = ST_TMO;
                end
            end
            ST_HOLD, ST_SPUR, ST_TMO: begin
                if (!cpu_iack_i) begin
                    state_d = ST_REL;
                end
            end
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        seen_low_d = seen_low_q;
        if (!cpu_iack_i) begin
            seen_low_d = 1'b1;
        end else if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
            seen_low_d = 1'b0;
        end

        spur_cnt_d = spur_cnt_q;
        if (((state_d == ST_SPUR) || (state_d == ST_TMO)) && (state_d != state_q)
            && (spur_cnt_q != 8'hFF)) begin
            spur_cnt_d = spur_cnt_q + 8'd1;
        end

        // Outputs are decoded from the next state so they come straight off flops
        int_ack_d = (state_d == ST_ACK) || (state_d == ST_HOLD);
        dtack_d   = (state_d == ST_HOLD) || (state_d == ST_SPUR) || ((state_d == ST_TMO) && !AUTOVEC);
        avec_d    = (state_d == ST_TMO) && AUTOVEC;
        cpu_vec_d = 8'd0;
        if (state_d == ST_HOLD) begin
            cpu_vec_d = vec_d;
        end else if ((state_d == ST_SPUR) || ((state_d == ST_TMO) && !AUTOVEC)) begin
            cpu_vec_d = SPURIOUS_VEC;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q    <= ST_IDLE;
            vec_q      <= 8'd0;
            seen_low_q <= 1'b0;
            spur_cnt_q <= 8'd0;
            cpu_vec_q  <= 8'd0;
            dtack_q    <= 1'b0;
            avec_q     <= 1'b0;
            int_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            seen_low_q <= seen_low_d;
            spur_cnt_q <= spur_cnt_d;
            cpu_vec_q  <= cpu_vec_d;
            dtack_q    <= dtack_d;
            avec_q     <= avec_d;
            int_ack_q  <= int_ack_d;
        end
    end

    assign cpu_vec_o    = cpu_vec_q;
    assign cpu_dtack_o  = dtack_q;
    assign ic_int_ack_o = int_ack_q;
    assign spur_cnt_o   = spur_cnt_q;
`ifdef IACK_AUTOVEC_EN
    assign cpu_avec_o   = avec_q;
`else
    assign cpu_avec_o   = 1'b0;
`endif

endmodule

// File: doc/iack_sequencer.md
# iack_sequencer

Sequences the 68000 interrupt-acknowledge (IACK) cycle against the interrupt controller. It sits between the CPU bus-cycle decoder and the interrupt controller. It drives the controller's `int_ack` handshake, captures the returned vector and presents it to the CPU with DTACK. It resolves level mismatches and unanswered acknowledges into a spurious-interrupt response, and keeps a saturating count of spurious events for diagnostics.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles allowed in ACK for the controller to answer; legal range 2..255.
- `SPURIOUS_VEC`, 8'd24: vector returned on a spurious interrupt (68000 spurious-interrupt vector).

Ports:
- `wb_clk_i`  in  1  system clock; all logic on its rising edge.
- `wb_reset_n_i`  in  1  asynchronous, active-low reset.
- `cpu_iack_i`  in  1  high while the CPU runs an IACK cycle (FC=111, CPU-space type 0xF); synchronous to `wb_clk_i`.
- `cpu_lvl_i`  in  3  level being acknowledged (A3:A1); valid while `cpu_iack_i` is high.
- `cpu_vec_o`  out  8  vector to the CPU data bus D7:D0.
- `cpu_dtack_o`  out  1  vector valid and cycle may terminate.
- `cpu_avec_o`  out  1  request autovector (VPA path); compiled in only with the macro, otherwise tied 0.
- `ic_ipl_i`  in  3  current IPL from the interrupt controller.
- `ic_int_ack_o`  out  1  acknowledge request to the interrupt controller.
- `ic_dat_i`  in  8  vector from the controller.
- `ic_ack_ni`  in  1  active-low controller acknowledge; `ic_dat_i` is valid while low.
- `spur_cnt_o`  out  8  saturating count of spurious or timed-out acknowledges.

## Operation
- States: IDLE, ACK, HOLD, SPUR, TMO, REL.
- IDLE:
  - All strobes are 0 and `cpu_vec_o` = 0.
  - On `cpu_iack_i` = 1: if `ic_ipl_i` = 0 or `ic_ipl_i` ≠ `cpu_lvl_i`, go to SPUR.
  - Otherwise go to ACK and load the timer with `TIMEOUT`-1.
- ACK:
  - `ic_int_ack_o` = 1; the timer decrements each cycle.
  - Priority: `cpu_iack_i` = 0 → REL (abort); else `ic_ack_ni` = 0 → latch `ic_dat_i` into the vector register, go to HOLD; else timer = 0 → TMO.
- HOLD:
  - `ic_int_ack_o` = 1, `cpu_dtack_o` = 1, `cpu_vec_o` = latched vector.
  - Leave for REL when `cpu_iack_i` = 0.
- SPUR:
  - `cpu_vec_o` = `SPURIOUS_VEC`, `cpu_dtack_o` = 1, `ic_int_ack_o` = 0.
  - Leave for REL when `cpu_iack_i` = 0.
- TMO: behaviour is set by the macro (see Configuration). Leave for REL when `cpu_iack_i` = 0.
- REL:
  - All strobes are 0 for exactly one cycle, then IDLE.
  - The falling edge of `ic_int_ack_o` clears the controller's IPL.
  - REL also guarantees a minimum 1-cycle low gap on `ic_int_ack_o` between back-to-back IACKs.
- `spur_cnt_o` increments by 1 on each entry into SPUR or TMO and saturates at 255.
- The vector register and `spur_cnt_o` change only as stated above.

## Timing
- Reset value of every output and state register is 0; the state is IDLE and the vector register is 0. Reset takes effect immediately (asynchronous); release is synchronous to `wb_clk_i`.
- Reset asserted mid-cycle: outputs go to 0 at once; after release the block returns to IDLE, even if `cpu_iack_i` is still high. It does not re-enter ACK until `cpu_iack_i` has gone low and then high again. This is enforced by a `seen_low` flag, which is cleared by reset.
- Normal path latency: `cpu_iack_i` high at edge N → `ic_int_ack_o` high after N+1. If `ic_ack_ni` is low at edge M, `cpu_dtack_o` and the vector are valid after M+1.
- Fastest path: `cpu_dtack_o` is asserted 2 cycles after IACK is seen.
- Spurious (mismatch) path: `cpu_dtack_o` is asserted 1 cycle after IACK is seen.
- Timeout: TMO is entered `TIMEOUT` cycles after ACK is entered.
- Simultaneous ACK events: `cpu_iack_i` falling has priority over `ic_ack_ni` low, which has priority over timer expiry.
- Outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `IACK_AUTOVEC_EN`.
- Defined: TMO asserts `cpu_avec_o` = 1, with `cpu_dtack_o` = 0 and `cpu_vec_o` = 0. The CPU then uses autovector 24+level.
- Undefined:
  - TMO behaves exactly like SPUR: `SPURIOUS_VEC` with DTACK.
  - `cpu_avec_o` is a constant 0.
- SPUR behaviour is identical in both builds.

## Structure
- Shared package `m68kwb_pkg` holds:
  - the state encoding constants (3-bit: IDLE=0, ACK=1, HOLD=2, SPUR=3, TMO=4, REL=5);
  - the default `SPURIOUS_VEC`;
  - the autovector base constant 24.
- One sub-module, `iack_timer`:
  - 8-bit loadable down-counter;
  - inputs: load, load value;
  - output: `expired` (count = 0).

## Test plan
- Normal acknowledge: `ic_ipl_i` = 5, `cpu_lvl_i` = 5, controller returns 0x40 two cycles after `int_ack` → `cpu_vec_o` = 0x40 with DTACK. `cpu_iack_i` low → exactly 1 cycle of REL, `ic_int_ack_o` low, `spur_cnt_o` = 0.
- Level mismatch: `ic_ipl_i` = 3, `cpu_lvl_i` = 6 → `ic_int_ack_o` never asserted, vector 24 with DTACK 1 cycle after IACK, `spur_cnt_o` = 1.
- Timeout with `TIMEOUT` = 4 and `ic_ack_ni` held high:
  - macro undefined → vector 24 with DTACK after 4 ACK cycles, count +1;
  - macro defined → `cpu_avec_o` = 1 and DTACK = 0.
- CPU abort: `cpu_iack_i` drops while in ACK → REL then IDLE, no DTACK, count unchanged.
- Reset asserted in HOLD with `cpu_iack_i` held high → all outputs 0 immediately. No new ACK until `cpu_iack_i` goes low and then high again.
- Saturation: 260 back-to-back mismatched IACKs → `spur_cnt_o` = 255 and does not wrap.
